// File: rtl/tof_cmd_dispatcher.sv
// Shares one I2C engine among up to eight ToF sensor channels using round-robin arbitration.
// Define TOF_CMD_TIMEOUT_EN to add a WAIT timeout that aborts the engine and flags ERROR.
module tof_cmd_dispatcher #(
  parameter int NUM_SENSORS    = 8,
  parameter int CMD_W          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CMD_W*NUM_SENSORS-1:0] cmd_in,
  output logic [2*NUM_SENSORS-1:0]     status_out,
  output logic                         i2c_req,
  output logic [2:0]                   i2c_sel,
  output logic [CMD_W-1:0]             i2c_op,
  input  logic                         i2c_ack,
  input  logic                         i2c_done,
  input  logic                         i2c_err,
  output logic                         i2c_abort
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NUM_SENSORS-1:0] pending;
  logic [CMD_W-1:0]       cmd_lat [NUM_SENSORS];
  logic [1:0]             chan_st [NUM_SENSORS];
  logic [2:0]             rr_ptr;
  logic                   grant_found;
  logic [2:0]             grant_idx;
  logic [3:0]             scan_idx;
  logic                   timeout_hit;
  logic                   finish_ok;
  logic                   finish_err;

  // Scan from rr_ptr (the channel after the last one served) and take the first pending one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    scan_idx    = 4'd0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      scan_idx = {1'b0, rr_ptr} + 4'(i);
      if (scan_idx >= 4'(NUM_SENSORS)) begin
        scan_idx = scan_idx - 4'(NUM_SENSORS);
      end
      if (!grant_found && pending[scan_idx[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[2:0];
      end
    end
  end

`ifdef TOF_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != S_WAIT) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign i2c_abort   = timeout_hit && !i2c_done && !i2c_err;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign i2c_abort      = 1'b0;
`endif

  // Error beats done; done beats a timeout landing in the same cycle.
  assign finish_err = (state == S_WAIT) && (i2c_err || (timeout_hit && !i2c_done));
  assign finish_ok  = (state == S_WAIT) && i2c_done && !i2c_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i2c_req   = 1'b0;
    case (state)
      S_IDLE:   if (|pending) state_nxt = S_ARB;
      S_ARB:    state_nxt = S_REQ;
      S_REQ: begin
        i2c_req = 1'b1;
        if (i2c_ack) state_nxt = S_WAIT;
      end
      S_WAIT:   if (finish_ok || finish_err) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_sel <= 3'd0;
      i2c_op  <= '0;
      rr_ptr  <= 3'd0;
    end else if (state == S_ARB && grant_found) begin
      i2c_sel <= grant_idx;
      i2c_op  <= cmd_lat[grant_idx];
      rr_ptr  <= (grant_idx == 3'(NUM_SENSORS - 1)) ? 3'd0 : grant_idx + 3'd1;
    end
  end

  // The command is captured on detection, so later cmd_in edits cannot alter an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int k = 0; k < NUM_SENSORS; k++) begin
        chan_st[k] <= ST_IDLE;
        cmd_lat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        if (state == S_ARB && grant_found && grant_idx == 3'(k)) begin
          pending[k] <= 1'b0;
        end
        case (chan_st[k])
          ST_IDLE: begin
            if (cmd_in[CMD_W*k +: CMD_W] != '0) begin
              chan_st[k] <= ST_BUSY;
              pending[k] <= 1'b1;
              cmd_lat[k] <= cmd_in[CMD_W*k +: CMD_W];
            end
          end
          ST_BUSY: begin
            if (i2c_sel == 3'(k)) begin
              if (finish_err) begin
                chan_st[k] <= ST_ERR;
              end else if (finish_ok) begin
                chan_st[k] <= ST_DONE;
              end
            end
          end
          default: begin
            if (cmd_in[CMD_W*k +: CMD_W] == '0) begin
              chan_st[k] <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    status_out = '0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      status_out[2*k +: 2] = chan_st[k];
    end
  end

endmodule

// File: tb/tb_tof_cmd_dispatcher.sv
// Randomized self-checking bench for tof_cmd_dispatcher; a transaction-level model predicts
// the service order, latched opcodes and per-channel status.
module tb_tof_cmd_dispatcher;

  localparam int N = 8;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [W*N-1:0] cmd_in = '0;
  logic [2*N-1:0] status_out;
  logic           i2c_req;
  logic [2:0]     i2c_sel;
  logic [W-1:0]   i2c_op;
  logic           i2c_ack = 1'b0;
  logic           i2c_done = 1'b0;
  logic           i2c_err = 1'b0;
  logic           i2c_abort;

  tof_cmd_dispatcher #(
    .NUM_SENSORS   (N),
    .CMD_W         (W),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_in    (cmd_in),
    .status_out(status_out),
    .i2c_req   (i2c_req),
    .i2c_sel   (i2c_sel),
    .i2c_op    (i2c_op),
    .i2c_ack   (i2c_ack),
    .i2c_done  (i2c_done),
    .i2c_err   (i2c_err),
    .i2c_abort (i2c_abort)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: channel status, captured command, pending set, last channel served.
  logic [1:0]   m_status [N];
  logic [W-1:0] m_cmd [N];
  bit           m_pending [N];
  int           m_last;

  int fix_ack = -1;
  int fix_wait = -1;
  int fix_out = -1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < N; k++) begin
      m_status[k]  = 2'd0;
      m_cmd[k]     = '0;
      m_pending[k] = 1'b0;
    end
    m_last = N - 1;
  endfunction

  function automatic void modelCmdWrite(input int k, input logic [W-1:0] v);
    if (m_status[k] == 2'd0 && v != '0) begin
      m_status[k]  = 2'd1;
      m_pending[k] = 1'b1;
      m_cmd[k]     = v;
    end else if (m_status[k] >= 2'd2 && v == '0) begin
      m_status[k] = 2'd0;
    end
  endfunction

  function automatic int modelNext();
    for (int i = 1; i <= N; i++) begin
      int idx = (m_last + i) % N;
      if (m_pending[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [W*N-1:0] v);
    @(negedge clk);
    cmd_in = v;
    for (int k = 0; k < N; k++) modelCmdWrite(k, v[W*k +: W]);
  endtask

  task automatic checkStatusAll();
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("status_ch%0d", k), 32'(status_out[2*k +: 2]), 32'(m_status[k]));
    end
  endtask

  task automatic waitReq(output int cyc);
    cyc = 0;
    while (!i2c_req && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Acts as the I2C engine for every request the model expects, in model order.
  task automatic serveRound(input bit fresh);
    bit first = 1'b1;
    int exp_ch, cyc, d, w, o;
    while (modelNext() >= 0) begin
      exp_ch = modelNext();
      waitReq(cyc);
      if (!i2c_req) begin
        checkOutput("req_seen", 32'(i2c_req), 32'd1);
        return;
      end
      if (fresh && first) checkOutput("req_latency", cyc, 3);
      first = 1'b0;
      checkOutput("sel", 32'(i2c_sel), exp_ch);
      checkOutput("op", 32'(i2c_op), 32'(m_cmd[exp_ch]));
      m_pending[exp_ch] = 1'b0;
      m_last = exp_ch;
      d = (fix_ack >= 0) ? fix_ack : int'($urandom_range(0, 3));
      repeat (d) begin
        @(negedge clk);
        checkOutput("req_held", 32'(i2c_req), 32'd1);
        checkOutput("sel_stable", 32'(i2c_sel), exp_ch);
      end
      i2c_ack = 1'b1;
      @(negedge clk);
      i2c_ack = 1'b0;
      checkOutput("req_low_wait", 32'(i2c_req), 32'd0);
      for (int k = 0; k < N; k++) begin
        if (m_status[k] != 2'd0) cmd_in[W*k +: W] = (m_cmd[k] % 4'd15) + 4'd1;
      end
      w = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 20));
      repeat (w) @(negedge clk);
      checkOutput("busy_in_wait", 32'(status_out[2*exp_ch +: 2]), 32'd1);
      o = (fix_out >= 0) ? fix_out : int'($urandom_range(0, 2));
      i2c_done = (o != 1);
      i2c_err  = (o != 0);
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_err  = 1'b0;
      m_status[exp_ch] = (o == 0) ? 2'd2 : 2'd3;
      checkOutput("op_held", 32'(i2c_op), 32'(m_cmd[exp_ch]));
      checkOutput("status_after", 32'(status_out[2*exp_ch +: 2]), 32'(m_status[exp_ch]));
    end
  endtask

  // Stray completion pulses outside WAIT must be ignored and nothing may be re-issued.
  task automatic idleCheck();
    @(negedge clk);
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_err  = 1'b1;
    @(negedge clk);
    i2c_err = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("no_reissue", 32'(i2c_req), 32'd0);
    end
    checkStatusAll();
  endtask

  task automatic clearAndCheck(input logic [W*N-1:0] v);
    applyStimulus(v);
    @(negedge clk);
    checkStatusAll();
  endtask

  task automatic longWaitTest();
    logic [W*N-1:0] v;
    int cyc;
    int abort_at;
    int aborts;
    int bad;
    v = '0;
    v[W*0 +: W] = 4'h3;
    applyStimulus(v);
    waitReq(cyc);
    checkOutput("lw_sel", 32'(i2c_sel), 32'd0);
    m_pending[0] = 1'b0;
    m_last = 0;
    i2c_ack = 1'b1;
    @(negedge clk);
    i2c_ack = 1'b0;
    abort_at = 0;
    aborts = 0;
    bad = 0;
`ifdef TOF_CMD_TIMEOUT_EN
    for (int c = 1; c <= 200; c++) begin
      if (i2c_abort) begin
        aborts++;
        if (abort_at == 0) abort_at = c;
      end
      @(negedge clk);
    end
    checkOutput("abort_cycle", abort_at, 100);
    checkOutput("abort_count", aborts, 1);
    m_status[0] = 2'd3;
    checkStatusAll();
`else
    for (int c = 1; c <= 10000; c++) begin
      if (status_out[1:0] != 2'b01 || i2c_abort) bad++;
      if (i2c_abort) aborts++;
      @(negedge clk);
    end
    checkOutput("wait_forever", bad, 0);
    checkOutput("abort_tied", aborts + abort_at, 0);
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
    m_status[0] = 2'd2;
    checkOutput("lw_done", 32'(status_out[1:0]), 32'd2);
`endif
    clearAndCheck('0);
  endtask

  task automatic resetMidWaitTest();
    logic [W*N-1:0] v;
    int cyc;
    v = '0;
    v[W*4 +: W] = 4'h5;
    applyStimulus(v);
    waitReq(cyc);
    checkOutput("rst_pre_sel", 32'(i2c_sel), 32'd4);
    checkOutput("rst_pre_op", 32'(i2c_op), 32'h5);
    i2c_ack = 1'b1;
    @(negedge clk);
    i2c_ack = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_status", 32'(status_out), 32'd0);
    checkOutput("rst_req", 32'(i2c_req), 32'd0);
    checkOutput("rst_sel", 32'(i2c_sel), 32'd0);
    checkOutput("rst_op", 32'(i2c_op), 32'd0);
    checkOutput("rst_abort", 32'(i2c_abort), 32'd0);
    @(negedge clk);
    checkOutput("rst_hold_req", 32'(i2c_req), 32'd0);
    checkOutput("rst_hold_abort", 32'(i2c_abort), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    for (int k = 0; k < N; k++) modelCmdWrite(k, cmd_in[W*k +: W]);
    serveRound(1'b1);
    idleCheck();
    clearAndCheck('0);
  endtask

  initial begin
    logic [W*N-1:0] v;
    modelReset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_status", 32'(status_out), 32'd0);
    checkOutput("reset_req", 32'(i2c_req), 32'd0);
    checkOutput("reset_sel", 32'(i2c_sel), 32'd0);
    checkOutput("reset_op", 32'(i2c_op), 32'd0);
    checkOutput("reset_abort", 32'(i2c_abort), 32'd0);
    rst_n = 1'b1;

    // Single channel with fixed ack and done timing.
    fix_ack = 3; fix_wait = 50; fix_out = 0;
    v = '0; v[W*0 +: W] = 4'h5;
    applyStimulus(v);
    serveRound(1'b1);
    idleCheck();
    clearAndCheck('0);
    fix_ack = -1; fix_wait = -1; fix_out = -1;

    // Serve channel 5, then issue 2, 5, 7 together: expect order 7, 2, 5.
    v = '0; v[W*5 +: W] = 4'h9;
    applyStimulus(v);
    serveRound(1'b1);
    clearAndCheck('0);
    v = '0; v[W*2 +: W] = 4'h2; v[W*5 +: W] = 4'hA; v[W*7 +: W] = 4'h7;
    applyStimulus(v);
    serveRound(1'b1);
    idleCheck();
    clearAndCheck('0);

    // Simultaneous done and err on channel 3.
    fix_out = 2;
    v = '0; v[W*3 +: W] = 4'h1;
    applyStimulus(v);
    serveRound(1'b1);
    idleCheck();
    clearAndCheck('0);
    fix_out = 0;

    // Channel 1 rewritten from 1 to 2 during WAIT.
    v = '0; v[W*1 +: W] = 4'h1;
    applyStimulus(v);
    serveRound(1'b1);
    checkOutput("ch1_cmd_rewritten", 32'(cmd_in[W*1 +: W]), 32'h2);
    idleCheck();
    clearAndCheck('0);
    fix_out = -1;

    longWaitTest();

    for (int r = 0; r < 30; r++) begin
      v = '0;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1) v[W*k +: W] = W'($urandom_range(1, 15));
      end
      applyStimulus(v);
      serveRound(1'b1);
      idleCheck();
      v = cmd_in;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1) v[W*k +: W] = '0;
      end
      clearAndCheck(v);
    end
    clearAndCheck('0);

    resetMidWaitTest();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tof_cmd_dispatcher.md
TOF_CMD_DISPATCHER -- requirements
Module: tof_cmd_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_SENSORS, default 8, giving the number of ToF sensor channels (legal range 1..8).
REQ-002 The block SHALL have parameter CMD_W, default 4, giving the width of each per-channel command field.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the clk cycles allowed in WAIT before a timeout.
REQ-004 The block SHALL have a single clock domain and an asynchronous, active-low reset.
REQ-005 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- cmd_in  in  CMD_W*NUM_SENSORS  command nibbles from the PS register; channel k occupies [CMD_W*k +: CMD_W]; value 0 means idle/acknowledge.
- status_out  out  2*NUM_SENSORS  per-channel status: 00 IDLE, 01 BUSY, 10 DONE, 11 ERROR.
- i2c_req  out  1  request to the shared I2C engine.
- i2c_sel  out  3  index of the channel being served.
- i2c_op  out  CMD_W  command latched for the served channel.
- i2c_ack  in  1  the I2C engine accepted the request.
- i2c_done  in  1  one-cycle pulse: operation completed.
- i2c_err  in  1  one-cycle pulse: operation failed.
- i2c_abort  out  1  one-cycle pulse that aborts the I2C engine.

Function
REQ-006 A channel in IDLE with a nonzero cmd_in field SHALL become pending, and its status SHALL read BUSY from the next cycle.
REQ-007 Changes to a channel's cmd_in while it is BUSY, DONE or ERROR SHALL be ignored.
REQ-008 The dispatcher FSM SHALL have the states IDLE, ARB, REQ, WAIT and FINISH.
REQ-009 IDLE->ARB SHALL occur when any channel is pending.
REQ-010 ARB SHALL select a pending channel round-robin, starting at the channel after the last one served (after reset, channel 0 is checked first), and SHALL latch i2c_sel and i2c_op from that channel's command.
REQ-011 ARB->REQ SHALL take 1 cycle.
REQ-012 In REQ, i2c_req SHALL be held high with i2c_sel and i2c_op stable until i2c_ack is high; REQ->WAIT SHALL occur on the cycle i2c_ack is sampled high, and i2c_req SHALL be low in WAIT.
REQ-013 In WAIT, i2c_done SHALL set the served channel to DONE, and i2c_err SHALL set it to ERROR.
REQ-014 If i2c_done and i2c_err are high in the same cycle, i2c_err SHALL win and the channel SHALL go to ERROR.
REQ-015 WAIT->FINISH SHALL occur on i2c_done or i2c_err, and FINISH->IDLE SHALL take 1 cycle.
REQ-016 i2c_done or i2c_err pulses outside WAIT SHALL be ignored.
REQ-017 A DONE or ERROR channel SHALL return to IDLE one cycle after its cmd_in field reads 0.
REQ-018 A DONE or ERROR channel whose cmd_in field stays nonzero SHALL remain in DONE or ERROR and SHALL NOT be re-issued.
REQ-019 Latency SHALL be as follows: with no contention, i2c_req rises 2 cycles after the nonzero command is sampled; status_out updates on the cycle after i2c_done or i2c_err.
REQ-020 Channels k >= NUM_SENSORS SHALL not exist, and the corresponding i2c_sel values SHALL never be driven.

Reset
REQ-021 While rst_n is low, the FSM SHALL be in IDLE and every status_out field SHALL be 00.
REQ-022 While rst_n is low, i2c_req, i2c_abort, i2c_sel and i2c_op SHALL be 0, the round-robin pointer SHALL be 0, no channel SHALL be pending, and the timeout counter SHALL be 0.
REQ-023 Reset asserted mid-operation, including in REQ or WAIT, SHALL drop i2c_req immediately, SHALL NOT pulse i2c_abort, and SHALL discard all pending commands.
REQ-024 After rst_n deasserts, nonzero cmd_in fields SHALL be re-detected as new commands.

Configuration
REQ-025 With macro TOF_CMD_TIMEOUT_EN defined, a counter SHALL run in WAIT and clear on entry to WAIT.
REQ-026 With TOF_CMD_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL set the channel to ERROR, pulse i2c_abort for 1 cycle and go to FINISH.
REQ-027 With TOF_CMD_TIMEOUT_EN defined, i2c_done arriving in the timeout cycle SHALL take priority over the timeout.
REQ-028 With TOF_CMD_TIMEOUT_EN undefined, WAIT SHALL last indefinitely, i2c_abort SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-029 Channel 0 cmd 0x5, i2c_ack after 3 cycles, i2c_done 50 cycles later -> status_out[1:0] goes 01 then 10; after cmd cleared to 0 it returns to 00.
REQ-030 Channels 2, 5 and 7 issued in the same cycle with last served = 5 -> service order is 7, 2, 5, and each i2c_op matches its nibble.
REQ-031 Channel 3 cmd 0x1 with i2c_done and i2c_err in the same cycle -> status 11 and no re-issue while cmd stays 0x1.
REQ-032 Channel 1 cmd changed from 0x1 to 0x2 during WAIT -> i2c_op stays 0x1 and status ends in 10.
REQ-033 With TOF_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, no i2c_done -> i2c_abort pulses once at cycle 100 of WAIT and status goes to 11; without the macro, status stays 01 for 10000 cycles.
REQ-034 rst_n low during WAIT for channel 4 -> all status 00 and i2c_req 0; after release with cmd still 0x5, channel 4 is re-issued.
